gpio_in: RTL

//  Memory-mapped GPIO input peripheral; the input-direction counterpart of the GPIO output port.

---
 rtl/gpio_in.sv | 116 +++++++++++
 1 files changed

// File: rtl/gpio_in.sv
// gpio_in: memory-mapped GPIO input peripheral.
// Four active-low pins are synchronised, debounced and edge-detected. Sticky rise/fall
// flags drive a level interrupt through a per-flag enable mask.
module gpio_in #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [3:0]        gpio_pins,
    output logic              irq_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       ADDR_CTRL = 4'h0;
    localparam logic [3:0]       ADDR_DATA = 4'h4;
    localparam logic [3:0]       ADDR_STAT = 4'h8;
    localparam logic [3:0]       ADDR_RAW  = 4'hC;

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [3:0]       raw_lvl;
    logic [3:0]       stable;
    logic [3:0]       stable_nxt;
    logic [CNT_W-1:0] cnt     [4];
    logic [CNT_W-1:0] cnt_nxt [4];
    logic [3:0]       rise_set;
    logic [3:0]       fall_set;
    logic [7:0]       ctrl;
    logic [7:0]       status;
    logic [7:0]       clr_mask;
    logic             ctrl_wr;
    logic [3:0]       raddr_reg;
    logic             unused_bits;

    // Only the low nibble of each address and the low byte of write data are decoded.
    assign unused_bits = ^{waddr_i[ADDR_W-1:4], raddr_i[ADDR_W-1:4], wdata_i[DATA_W-1:8]};

    // Pins are active-low: a low synchronised pin reads as level 1.
    assign raw_lvl = ~sync_p1;

    // Debounce: a level differing from the accepted one must persist DEBOUNCE_CYCLES samples.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (raw_lvl[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = raw_lvl[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge flags fire on the same clock as the debounced level changes; decode bus writes.
    always_comb begin
        rise_set = stable_nxt & ~stable;
        fall_set = ~stable_nxt & stable;
        ctrl_wr  = wen_i && (waddr_i[3:0] == ADDR_CTRL);
        clr_mask = (wen_i && (waddr_i[3:0] == ADDR_STAT)) ? wdata_i[7:0] : 8'h00;
    end

    // All state: synchroniser, debounce, CTRL, sticky STATUS (set beats clear), read address.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            // stage p0 -> p1: synchroniser flops idle at the released-pin level
            sync_p0   <= 4'hF;
            sync_p1   <= 4'hF;
            stable    <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            ctrl      <= 8'h00;
            status    <= 8'h00;
            raddr_reg <= 4'h0;
        end else begin
            // stage p0 -> p1: two-flop synchroniser
            sync_p0   <= gpio_pins;
            sync_p1   <= sync_p0;
            stable    <= stable_nxt;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (ctrl_wr) begin
                ctrl <= wdata_i[7:0];
            end
            status    <= (status & ~clr_mask) | {fall_set, rise_set};
            raddr_reg <= raddr_i[3:0];
        end
    end

    // Read mux from the registered read address gives one cycle of read latency.
    always_comb begin
        rdata_o = '0;
        case (raddr_reg)
            ADDR_CTRL: rdata_o[7:0] = ctrl;
            ADDR_DATA: rdata_o[3:0] = stable;
            ADDR_STAT: rdata_o[7:0] = status;
            ADDR_RAW:  rdata_o[3:0] = raw_lvl;
            default:   rdata_o      = '0;
        endcase
    end

    // Level interrupt: any enabled sticky flag.
    assign irq_o = |(status & ctrl);

endmodule
